// File: rtl/adbg_crc_pkg.sv
// Shared constants and check-FSM state encoding for the debug CRC engine.
package adbg_crc_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_e;

endpackage

// File: rtl/adbg_crc_step.sv
// One reflected (LSB-first) CRC step: absorbs a single data bit into the CRC value.
module adbg_crc_step
    import adbg_crc_pkg::*;
#(
    parameter int                 CRC_W = 32,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC32_POLY_REFL)
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_d,
    output logic [CRC_W-1:0] o_crc_next
);

    logic w_fb;

    assign w_fb       = i_crc[0] ^ i_d;
    assign o_crc_next = {1'b0, i_crc[CRC_W-1:1]} ^ (w_fb ? POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/adbg_crc_engine.sv
// Parametrised CRC engine with LSB-first serial output and a receive-side CRC check FSM.
module adbg_crc_engine
    import adbg_crc_pkg::*;
#(
    parameter int                 CRC_W = 32,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(CRC32_POLY_REFL),
    parameter logic [CRC_W-1:0]   INIT  = CRC_W'(CRC32_INIT),
    parameter int                 DIN_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DIN_W-1:0]  data_in,
    input  logic              data_valid,
    input  logic              shift,
    input  logic              chk_start,
    input  logic              chk_bit,
    input  logic              chk_valid,
    output logic [CRC_W-1:0]  crc_out,
    output logic              serial_out,
    output logic              chk_busy,
    output logic              chk_done,
    output logic              chk_ok
);

    localparam int CNT_W = $clog2(CRC_W + 1);

    crc_state_e       r_state;
    crc_state_e       w_state_nxt;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_nxt;
    logic [CRC_W-1:0] w_crc_data;
    logic [CRC_W-1:0] w_crc_shr;
    logic [CRC_W-1:0] w_crc_host;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ok;
    logic             w_ok_nxt;
    logic             w_ok_beat;
    logic             r_chk_ok;
    logic             w_chk_ok_nxt;
    logic [DIN_W-1:0] w_din;

    // Unknown data bits count as zero so an X on the bus cannot poison the CRC.
    always_comb begin
        w_din = {DIN_W{1'b0}};
        for (int i = 0; i < DIN_W; i++) begin
            w_din[i] = (data_in[i] === 1'b1);
        end
    end

    for (genvar gi = 0; gi < DIN_W; gi++) begin : g_step
        logic [CRC_W-1:0] w_prev;
        logic [CRC_W-1:0] w_next;
        if (gi == 0) begin : g_first
            assign w_prev = r_crc;
        end else begin : g_rest
            assign w_prev = g_step[gi-1].w_next;
        end
        adbg_crc_step #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_step (
            .i_crc      (w_prev),
            .i_d        (w_din[gi]),
            .o_crc_next (w_next)
        );
    end

    assign w_crc_data = g_step[DIN_W-1].w_next;
    assign w_crc_shr  = {1'b0, r_crc[CRC_W-1:1]};
    assign w_crc_host = data_valid ? w_crc_data : (shift ? w_crc_shr : r_crc);
    assign w_ok_beat  = r_ok & (chk_bit == r_crc[0]);

    // Next-state logic: clr overrides everything, the check owns the register while busy.
    always_comb begin
        w_state_nxt  = r_state;
        w_crc_nxt    = r_crc;
        w_cnt_nxt    = r_cnt;
        w_ok_nxt     = r_ok;
        w_chk_ok_nxt = r_chk_ok;
        if (clr) begin
            w_state_nxt  = ST_IDLE;
            w_crc_nxt    = INIT;
            w_cnt_nxt    = {CNT_W{1'b0}};
            w_ok_nxt     = 1'b0;
            w_chk_ok_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_crc_nxt = w_crc_host;
                    if (chk_start) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_ok_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (chk_valid) begin
                        w_crc_nxt = w_crc_shr;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_ok_nxt  = w_ok_beat;
                        if (r_cnt == CNT_W'(CRC_W - 1)) begin
                            w_state_nxt  = ST_DONE;
                            w_chk_ok_nxt = w_ok_beat;
                        end else begin
                            w_state_nxt = ST_CHECK;
                        end
                    end else begin
                        w_crc_nxt = r_crc;
                    end
                end
                ST_DONE: begin
                    w_crc_nxt   = w_crc_host;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_crc    <= INIT;
            r_cnt    <= {CNT_W{1'b0}};
            r_ok     <= 1'b0;
            r_chk_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_crc    <= w_crc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ok     <= w_ok_nxt;
            r_chk_ok <= w_chk_ok_nxt;
        end
    end

    assign crc_out    = r_crc;
    assign serial_out = r_crc[0];
    assign chk_busy   = (r_state == ST_CHECK);
    assign chk_done   = (r_state == ST_DONE);
    assign chk_ok     = r_chk_ok;

endmodule

// File: doc/adbg_crc_engine.md
# adbg_crc_engine

Parametrised CRC engine for the Advanced Debug Module. It is the successor to the fixed 1-bit serial CRC32:
- Width, polynomial, initial value and data bits absorbed per cycle are all parameters.
- Adds a self-contained receive-side check FSM. The FSM compares an incoming serial CRC against the computed value and reports match/mismatch.
- Sits between the JTAG shift datapath and the module-select/bus-access logic. It computes CRC over outgoing and incoming debug data and shifts the result out LSB-first.

## Interface

Parameters:
- CRC_W, 32, CRC register width; legal range 8..64.
- POLY, 32'hEDB88320, reflected (LSB-first) polynomial, CRC_W bits.
- INIT, 32'hFFFFFFFF, value loaded on reset and clr, CRC_W bits.
- DIN_W, 1, data bits absorbed per data_valid cycle; legal range 1..CRC_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous reload of INIT; aborts any check.
- data_in  in  DIN_W  data; bit 0 is absorbed first.
- data_valid  in  1  absorb data_in this cycle.
- shift  in  1  shift CRC right by one, zero fill.
- chk_start  in  1  begin a CRC_W-bit compare.
- chk_bit  in  1  received CRC bit, LSB-first.
- chk_valid  in  1  chk_bit valid this cycle.
- crc_out  out  CRC_W  CRC register.
- serial_out  out  1  crc_out[0].
- chk_busy  out  1  check FSM in CHECK.
- chk_done  out  1  one-cycle pulse at check completion.
- chk_ok  out  1  result of the last completed check.

## Operation

- One-bit step: fb = crc[0] ^ d; crc_next = (crc >> 1) ^ (fb ? POLY : 0).
- With DIN_W > 1, steps are chained combinationally in one cycle: data_in[0] first, data_in[DIN_W-1] last.
- Register priority in IDLE: clr > data_valid > shift > hold. Identical to the 1-bit predecessor.
- Check FSM states:
  - IDLE: accepts chk_start; moves to CHECK, bit counter = 0, internal ok flag = 1.
  - CHECK: on each chk_valid, if chk_bit != crc[0] the ok flag is cleared; crc shifts right with zero fill; counter increments. When the counter reaches CRC_W, move to DONE.
  - DONE: chk_done = 1, chk_ok = ok flag; move to IDLE next cycle.
- In CHECK, data_valid, shift and chk_start are ignored.
- Counter width is $clog2(CRC_W+1).
- chk_ok holds its value until the next DONE, clr, or reset.
- clr in any state:
  - crc = INIT, FSM → IDLE.
  - chk_ok = 0, chk_done = 0; counter cleared.
- Simulation only: X on data_in is treated as 0 when data_valid = 1.

## Timing

- Reset values: crc_out = INIT, serial_out = INIT[0], chk_busy = 0, chk_done = 0, chk_ok = 0, FSM = IDLE.
- Reset mid-check returns everything to the reset values immediately (asynchronous).
- crc_out updates on the clock edge after data_valid or shift: latency 1 cycle. serial_out is combinational from the register, with no extra delay.
- chk_start accepted at edge N: chk_busy = 1 from N+1. A chk_valid in cycle N itself is ignored.
- Last chk_valid accepted at edge M: chk_done = 1 and chk_ok valid in cycle M+1; chk_busy = 0 in M+1.
- chk_valid may have gaps. Only asserted cycles count.
- Simultaneous chk_start and data_valid in IDLE: the data is absorbed and the FSM enters CHECK.
- Simultaneous clr and chk_start: clr wins and the FSM stays in IDLE.

## Structure

- Package adbg_crc_pkg:
  - constants CRC32_POLY_REFL = 32'hEDB88320 and CRC32_INIT = 32'hFFFFFFFF;
  - FSM state typedef (IDLE, CHECK, DONE).
- Sub-module adbg_crc_step: purely combinational one-bit step (crc, d → crc_next), parametrised by CRC_W/POLY. It is instantiated DIN_W times in a generate chain.
- The top holds the CRC register, the priority mux, the counter and the FSM.

## Test plan

- Reset, DIN_W=1, then data_valid with data_in=0 for one cycle → crc_out = 32'h92477CDF, serial_out = 1.
- DIN_W=8: bytes "123456789" (0x31..0x39) on 9 consecutive cycles → crc_out = 32'h340BC6D9 (~0xCBF43926).
- DIN_W=1: same 72 bits, LSB-first per byte, with random gaps in data_valid → same 32'h340BC6D9. Then 32 shift pulses → serial_out sequence equals 0x340BC6D9 LSB-first, and crc_out = 0.
- Check pass and fail:
  - After "123456789", chk_start, then 32 chk_valid beats carrying 0x340BC6D9 LSB-first → chk_done pulses one cycle after the 32nd beat, chk_ok = 1.
  - Repeat with bit 17 flipped → chk_ok = 0.
- Abort cases:
  - clr after 10 check beats → chk_busy = 0, chk_ok = 0, crc_out = INIT, no chk_done.
  - rst_n low mid-check → all outputs at reset values.
  - data_valid and shift asserted during CHECK → no effect on the check result.
- Priority: clr, data_valid and shift asserted together → crc_out = INIT. data_valid and shift together → only data absorbed.
